regb_feeder: RTL

- Operand sequencer directly upstream of register B.
- Accepts operand words on a valid/ready stream and buffers them in a small FIFO.
- Issues single-cycle load_b pulses with data_in_b to register B.
- Raises b_valid in the cycle the loaded word appears at register B's pipelined outputs, so the downstream datapath knows when the B operand is fresh.

---
 rtl/regb_feeder.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/regb_feeder.sv
// regb_feeder: operand sequencer directly upstream of register B.
//
// Operand words arrive on a valid/ready stream and are buffered in a small
// FIFO. Each word is issued to register B as a single-cycle registered
// load_b strobe with data_in_b. b_valid marks the cycle in which that word
// appears at register B's pipelined outputs (LOAD_LATENCY cycles after
// load_b rises).
//
// Optional feature: define REGB_FEEDER_STATS_EN to add the 32-bit
// load_count output. It counts load_b pulses, wraps, and is cleared only
// by reset. Without the macro the port and counter do not exist.
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous, active-high; clears all control state at once
//   in_valid    upstream word present
//   in_ready    FIFO can accept this cycle (combinational)
//   in_data     upstream word
//   b_hold      consumer blocks new loads (issued loads still retire)
//   flush       synchronous discard of queued words
//   load_b      registered load strobe to register B
//   data_in_b   registered data to register B
//   b_valid     register B outputs hold a newly loaded word this cycle
//   fifo_count  number of queued entries
//   busy        sequencer not idle
//   load_count  (REGB_FEEDER_STATS_EN only) total loads issued
module regb_feeder #(
    parameter int DATA_WIDTH   = 32,
    parameter int FIFO_DEPTH   = 4,
    parameter int LOAD_LATENCY = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_WIDTH-1:0]         in_data,
    input  logic                          b_hold,
    input  logic                          flush,
    output logic                          load_b,
    output logic [DATA_WIDTH-1:0]         data_in_b,
    output logic                          b_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          busy
`ifdef REGB_FEEDER_STATS_EN
    ,
    output logic [31:0]                   load_count
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      cnt_nxt;
    logic [1:0]            state;
    logic [1:0]            state_nxt;
    logic                  push;
    logic                  pop;
    logic                  fifo_empty;
    logic                  inflight;

    // vld_p[i] is load_b delayed by i cycles; the last stage is b_valid.
    logic [LOAD_LATENCY:1] vld_p;

    // At full, a concurrent pop does not open in_ready (no pass-through).
    assign in_ready   = !reset && (cnt < CNT_W'(FIFO_DEPTH)) && !flush;
    assign push       = in_valid && in_ready;
    assign fifo_empty = (cnt == '0);
    assign pop        = !fifo_empty && !b_hold && !flush;

    assign b_valid    = vld_p[LOAD_LATENCY];
    assign fifo_count = cnt;
    assign busy       = (state != ST_IDLE);

    always_comb begin
        cnt_nxt = cnt;
        if (push && !pop) begin
            cnt_nxt = cnt + CNT_W'(1);
        end else if (pop && !push) begin
            cnt_nxt = cnt - CNT_W'(1);
        end
    end

    // A load is still "in flight" from the cycle load_b is high until the
    // cycle before b_valid; the final b_valid stage does not keep us busy,
    // so busy drops in the cycle right after b_valid.
    always_comb begin
        inflight = load_b;
        for (int i = 1; i < LOAD_LATENCY; i++) begin
            inflight = inflight | vld_p[i];
        end
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = inflight ? ST_RUN : ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        state_nxt = b_hold ? ST_HOLD : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (b_hold && !fifo_empty) begin
                        state_nxt = ST_HOLD;
                    end else if (fifo_empty && !inflight && !pop) begin
                        state_nxt = ST_IDLE;
                    end
                end
                ST_HOLD: begin
                    if (fifo_empty && !inflight && !pop) begin
                        state_nxt = ST_IDLE;
                    end else if (!b_hold) begin
                        state_nxt = ST_RUN;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // Storage carries data only; its contents are meaningless when empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // Issue stage -> latency pipeline
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt       <= '0;
            state     <= ST_IDLE;
            load_b    <= 1'b0;
            data_in_b <= '0;
            vld_p     <= '0;
        end else begin
            load_b <= pop;
            if (pop) begin
                data_in_b <= mem[rd_ptr];
            end

            vld_p[1] <= load_b;
            for (int i = 2; i <= LOAD_LATENCY; i++) begin
                vld_p[i] <= vld_p[i-1];
            end

            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                cnt    <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                cnt <= cnt_nxt;
            end

            state <= state_nxt;
        end
    end

`ifdef REGB_FEEDER_STATS_EN
    // Counts at the edge that raises load_b; wraps naturally at 2^32.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            load_count <= '0;
        end else if (pop) begin
            load_count <= load_count + 32'd1;
        end
    end
`endif

endmodule
